// File: rtl/load_store_unit.sv
// RV32I load/store unit: converts core loads/stores into word-aligned valid/ready memory beats.
// Sub-word stores use read-modify-write; illegal or misaligned accesses respond with an error.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [DATA_WIDTH-1:0] ZERO_D = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ZERO_A = {ADDR_WIDTH{1'b0}};

  function automatic logic is_illegal(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic illegal;
    illegal = 1'b0;
    if (write) begin
      case (funct3)
        F3_B:    illegal = 1'b0;
        F3_H:    illegal = off[0];
        F3_W:    illegal = (off != 2'b00);
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: illegal = 1'b0;
        F3_H, F3_HU: illegal = off[0];
        F3_W:        illegal = (off != 2'b00);
        default:     illegal = 1'b1;
      endcase
    end
    return illegal;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0]            funct3,
                                                        input logic [1:0]            off,
                                                        input logic [DATA_WIDTH-1:0] word);
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] result;
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    result = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      F3_BU:   result = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      F3_H:    result = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      F3_HU:   result = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      F3_W:    result = word;
      default: result = ZERO_D;
    endcase
    return result;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [2:0]            funct3,
                                                        input logic [1:0]            off,
                                                        input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] wdata);
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    case (funct3)
      F3_B:    result[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    result[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: result = wdata;
    endcase
    return result;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Next-state and next-output computation; all outputs are registered from these values.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = ZERO_D;
    resp_err_d   = 1'b0;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (is_illegal(req_write, req_funct3, req_addr[1:0])) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_write && (req_funct3 != F3_W)) begin
            state_d     = S_RMW_RD;
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = word_addr(req_addr);
            mem_wdata_d = ZERO_D;
          end else begin
            state_d     = S_ACCESS;
            mem_valid_d = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = word_addr(req_addr);
            mem_wdata_d = req_write ? req_wdata : ZERO_D;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        if (mem_ready) begin
          state_d      = S_RESP;
          mem_valid_d  = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = ZERO_A;
          mem_wdata_d  = ZERO_D;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? ZERO_D : load_extend(funct3_q, off_q, mem_rdata);
        end else begin
          state_d = S_ACCESS;
        end
      end

      // The old word is merged as it arrives, so the write beat carries the final word.
      S_RMW_RD: begin
        if (mem_ready) begin
          state_d     = S_RMW_WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_merge(funct3_q, off_q, mem_rdata, wdata_q);
        end else begin
          state_d = S_RMW_RD;
        end
      end

      S_RMW_WR: begin
        if (mem_ready) begin
          state_d      = S_RESP;
          mem_valid_d  = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = ZERO_A;
          mem_wdata_d  = ZERO_D;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_RMW_WR;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = ZERO_A;
        mem_wdata_d = ZERO_D;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      wdata_q      <= ZERO_D;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= ZERO_D;
      resp_err_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= ZERO_A;
      mem_wdata_q  <= ZERO_D;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side data-memory access unit. Sits between the processor execute stage and the word-wide data memory.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory transactions over a valid/ready handshake.
- Sub-word stores are done as read-modify-write. Load data is sign- or zero-extended, and misaligned or illegal accesses are flagged.

Parameters:
- ADDR_WIDTH, 32, byte-address width on the core and memory sides.
- DATA_WIDTH, 32, word width; the design supports 32 only (4 byte lanes).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  core access request
- req_ready  output  1  unit can accept a request (IDLE only)
- req_write  input  1  1=store, 0=load
- req_funct3  input  3  RV32I funct3 (size/sign)
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data (low bytes used for SB/SH)
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  DATA_WIDTH  extended load data (0 for stores/errors)
- resp_err  output  1  misaligned/illegal access, valid with resp_valid
- mem_valid  output  1  memory transaction request
- mem_ready  input  1  memory accepts/completes transaction this cycle
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  word address {addr[ADDR_WIDTH-1:2],2'b00}
- mem_wdata  output  DATA_WIDTH  full word to write
- mem_rdata  input  DATA_WIDTH  word read data, valid in the cycle mem_ready=1 with mem_we=0

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction aborts with no response; mem_valid is low from the next cycle.
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, funct3, addr and wdata, then check legality:
    - Illegal: load funct3 in {3,6,7}; store funct3 >2; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
    - Illegal → RESP with err=1 and no memory transaction.
    - LB/LH/LW/LBU/LHU/SW → ACCESS.
    - SB/SH → RMW_RD.
- ACCESS:
  - mem_valid=1, mem_we=latched write, mem_addr=word address.
  - mem_wdata=req_wdata for SW.
  - Hold all memory outputs stable until mem_ready=1.
  - On mem_ready, capture the extended load result (stores: 0) and go to RESP.
- RMW_RD:
  - mem_valid=1, mem_we=0.
  - On mem_ready, capture mem_rdata as the old word and go to RMW_WR.
- RMW_WR:
  - mem_valid=1, mem_we=1.
  - mem_wdata = old word with the addressed lane(s) replaced:
    - SB: byte lane addr[1:0] ← wdata[7:0].
    - SH: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
  - On mem_ready → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata and resp_err hold the latched values while resp_valid=1 and are 0 otherwise.
- Load extraction is little-endian:
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency with mem_ready tied to 1, request accepted in cycle 0:
  - Load/SW: memory beat in cycle 1, resp_valid in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
  - Each cycle with mem_ready=0 in a memory state adds one cycle.
- Requests arriving while req_ready=0 are ignored; the core holds req_valid until it sees req_ready.
- A new request is accepted no earlier than the cycle after resp_valid.
- mem_valid is never asserted in IDLE or RESP, and at most one memory transaction is outstanding.

Test Plan:
- Memory word 0x100 = 0x8899AABB, mem_ready=1; LB addr 0x101 → resp_rdata=0xFFFFFFAA in cycle 2; LBU addr 0x101 → 0x000000AA; LH addr 0x102 → 0xFFFF8899; LHU addr 0x102 → 0x00008899.
- SB addr 0x103, wdata=0x12345677, old word 0x8899AABB → one read of 0x100, then write 0x7799AABB; resp_valid in cycle 3, resp_err=0.
- SH addr 0x100, wdata=0x0000CAFE → memory word becomes 0x8899CAFE; SW addr 0x104, wdata=0xDEADBEEF → single write, no read beat.
- LW addr 0x102, SH addr 0x101, and load funct3=3 → resp_err=1, resp_rdata=0 in cycle 1, mem_valid never asserted.
- mem_ready held low 3 cycles during LW → mem_addr/mem_we stable throughout, resp_valid 3 cycles later; reset asserted mid-RMW_RD → next cycle mem_valid=0, req_ready=1, no resp_valid.
